// File: rtl/adc_burst_sched.sv
// adc_burst_sched: paces one-cycle sts pulses to the ADC acquire FSM and counts samples per burst; watchdog via ADC_SCHED_WDOG_EN.
// Latency: start -> sts 1 cycle, pulses P cycles apart; no backpressure, waits on eos_i and holds off the next sts until the FSM is idle.
module adc_burst_sched #(
  parameter int PER_W    = 24,
  parameter int CNT_W    = 16,
  parameter int WDOG_CYC = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [CNT_W-1:0] nsamp_i,
  input  logic             eos_i,
  output logic             sts_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] scount_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_EOS, S_PACE, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [PER_W-1:0] per_q, pcnt_q, per_lat;
  logic [CNT_W-1:0] nsamp_q, scount_q, scount_inc;
  logic             overrun_q, stop_pend_q;
  logic             accept, in_wait, last_smp, wdog_fire;

  if (PER_W < 2 || CNT_W < 1 || WDOG_CYC < 2) begin : g_bad_cfg
    $error("adc_burst_sched: unsupported parameter set");
  end

  assign accept     = (state_q == S_IDLE) && start_i && eos_i;
  assign per_lat    = (period_i < PER_W'(2)) ? PER_W'(2) : period_i;
  assign in_wait    = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_EOS);
  assign scount_inc = scount_q + 1'b1;
  assign last_smp   = (nsamp_q != '0) && (scount_inc == nsamp_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sts_o   = (state_q == S_ISSUE);
    done_o  = (state_q == S_FINISH);
    busy_o  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:     if (accept) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (wdog_fire)   state_d = S_FINISH;
        else if (!eos_i) state_d = S_WAIT_EOS;
      end
      // a stop arriving on the same edge as eos still ends the burst here
      S_WAIT_EOS: begin
        if (wdog_fire)  state_d = S_FINISH;
        else if (eos_i) state_d = (last_smp || stop_pend_q || stop_i) ? S_FINISH : S_PACE;
      end
      S_PACE: begin
        if (stop_i)              state_d = S_FINISH;
        else if (pcnt_q == '0)   state_d = S_ISSUE;
      end
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // period counter is loaded on entry to ISSUE so PACE can release exactly P cycles later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_q       <= '0;
      nsamp_q     <= '0;
      pcnt_q      <= '0;
      scount_q    <= '0;
      overrun_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        per_q   <= per_lat;
        nsamp_q <= nsamp_i;
      end
      if (state_d == S_ISSUE)
        pcnt_q <= (accept ? per_lat : per_q) - 1'b1;
      else if (state_q != S_IDLE && pcnt_q != '0)
        pcnt_q <= pcnt_q - 1'b1;
      if (accept)
        scount_q <= '0;
      else if (state_q == S_WAIT_EOS && eos_i && !wdog_fire)
        scount_q <= scount_inc;
      if (accept)
        overrun_q <= 1'b0;
      else if (in_wait && pcnt_q == '0)
        overrun_q <= 1'b1;
      if (accept)
        stop_pend_q <= 1'b0;
      else if (stop_i && (state_q == S_ISSUE || in_wait))
        stop_pend_q <= 1'b1;
    end
  end

`ifdef ADC_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wcnt_q;
  logic            timeout_q;

  // wcnt equals cycles since ISSUE, so firing at WDOG_CYC-1 puts FINISH WDOG_CYC cycles after ISSUE
  assign wdog_fire = in_wait && (wcnt_q == WD_W'(WDOG_CYC - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept)         timeout_q <= 1'b0;
      else if (wdog_fire) timeout_q <= 1'b1;
      if (state_d == S_ISSUE)
        wcnt_q <= '0;
      else if (state_q == S_ISSUE || in_wait)
        wcnt_q <= wcnt_q + 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign overrun_o = overrun_q;
  assign scount_o  = scount_q;

endmodule

// File: tb/tb_adc_burst_sched.sv
// Bench for adc_burst_sched: acquisition-FSM model drives eos, a timing-level reference predicts sts/done/overrun.
`timescale 1ns/1ps
module tb_adc_burst_sched;
  localparam int PER_W = 24;
  localparam int CNT_W = 16;
  localparam int WDOG  = 64;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [PER_W-1:0] period_i = '0;
  logic [CNT_W-1:0] nsamp_i = '0;
  logic             eos_i = 1'b1;
  logic             sts_o, busy_o, done_o, overrun_o, timeout_o;
  logic [CNT_W-1:0] scount_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sts_q[$];
  int done_q[$];
  int rise_q[$];
  int exp_q[$];
  bit exp_ov;
  int exp_done;
  bit last_sts = 1'b0;
  bit eos_stuck = 1'b0;
  int low_left = 0;
  int len_min = 1;
  int len_max = 1;

  adc_burst_sched #(.PER_W(PER_W), .CNT_W(CNT_W), .WDOG_CYC(WDOG)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .period_i(period_i), .nsamp_i(nsamp_i), .eos_i(eos_i),
    .sts_o(sts_o), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
    .timeout_o(timeout_o), .scount_o(scount_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc = cyc + 1;

  always @(negedge clk_i) begin
    last_sts = sts_o;
    if (sts_o) sts_q.push_back(cyc);
    if (done_o) done_q.push_back(cyc);
  end

  // acquisition FSM model: goes busy the cycle after sts for a random number of cycles
  always @(posedge clk_i) begin : fsm_model
    bit s;
    s = last_sts;
    #1;
    if (s && !eos_stuck) begin
      eos_i = 1'b0;
      low_left = $urandom_range(len_max, len_min);
    end else if (low_left > 0) begin
      low_left = low_left - 1;
      if (low_left == 0) begin
        eos_i = 1'b1;
        rise_q.push_back(cyc + 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input int p, input int n, output int k);
    @(posedge clk_i); #1;
    sts_q.delete(); done_q.delete(); rise_q.delete();
    period_i = PER_W'(p);
    nsamp_i  = CNT_W'(n);
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    k = cyc;
    period_i = PER_W'($urandom);
    nsamp_i  = CNT_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < budget) begin
      @(negedge clk_i);
      if (done_o) ok = 1'b1;
      i++;
    end
  endtask

  task automatic wait_sts(input int cnt, input int budget);
    int i;
    i = 0;
    while (sts_q.size() < cnt && i < budget) begin
      @(negedge clk_i);
      i++;
    end
  endtask

  // sts i+1 comes P after sts i unless eos is seen late, then the edge after; late eos means overrun
  task automatic run_model(input int k, input int p, input int cnt);
    int s;
    s = k;
    exp_q.delete();
    exp_ov = 1'b0;
    exp_done = -1;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(s);
      if (i < rise_q.size()) begin
        if (rise_q[i] >= s + p) exp_ov = 1'b1;
        exp_done = rise_q[i];
        s = (s + p > rise_q[i] + 1) ? s + p : rise_q[i] + 1;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    tick(3);
    vectors++;
    if ({sts_o, busy_o, done_o, overrun_o, timeout_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {sts_o, busy_o, done_o, overrun_o, timeout_o});
    end
    vectors++;
    if (scount_o !== '0) begin
      miscompares++;
      $display("FAIL reset_scount: got %0d want 0", scount_o);
    end
    rst_ni = 1'b1;
    tick(2);
    sts_q.delete();
    stop_i = 1'b1; tick(1); stop_i = 1'b0; tick(2);
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_stop_ignored: busy got %b want 0", busy_o);
    end
    eos_i = 1'b0; start_i = 1'b1; tick(1); start_i = 1'b0; eos_i = 1'b1; tick(3);
    vectors++;
    if (busy_o !== 1'b0 || sts_q.size() != 0) begin
      miscompares++;
      $display("FAIL start_eos_low_ignored: busy %b sts %0d want 0 0", busy_o, sts_q.size());
    end
  endtask

  task automatic test_timely();
    int k; bit ok;
    len_min = 40; len_max = 40;
    launch(100, 3, k);
    wait_done(700, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL timely_done: no done within budget"); end
    vectors++;
    if (rise_q.size() < 3 || cyc != rise_q[2]) begin
      miscompares++;
      $display("FAIL timely_done_cycle: got %0d want eos-seen edge of sample 3", cyc);
    end
    @(negedge clk_i);
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL timely_busy_fall: got %b want 0", busy_o); end
    tick(30);
    vectors++;
    if (sts_q.size() != 3) begin miscompares++; $display("FAIL timely_sts_count: got %0d want 3", sts_q.size()); end
    for (int i = 0; i < 3; i++) begin
      int got;
      got = (i < sts_q.size()) ? sts_q[i] : -1;
      vectors++;
      if (got != k + 100 * i) begin
        miscompares++;
        $display("FAIL timely_sts%0d: got cycle %0d want %0d", i, got, k + 100 * i);
      end
    end
    vectors++;
    if (scount_o !== 16'd3 || overrun_o !== 1'b0 || timeout_o !== 1'b0 || done_q.size() != 1) begin
      miscompares++;
      $display("FAIL timely_final: scount %0d ov %b to %b dones %0d want 3 0 0 1",
               scount_o, overrun_o, timeout_o, done_q.size());
    end
  endtask

  task automatic test_overrun();
    int k; bit ok;
    len_min = 30; len_max = 30;
    launch(10, 2, k);
    wait_done(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL overrun_done: no done within budget"); end
    tick(5);
    vectors++;
    if (sts_q.size() != 2 || rise_q.size() < 1 || sts_q[1] != rise_q[0] + 1) begin
      miscompares++;
      $display("FAIL overrun_sts2: sts count %0d second sts %0d want edge after eos seen",
               sts_q.size(), (sts_q.size() > 1) ? sts_q[1] : -1);
    end
    vectors++;
    if (overrun_o !== 1'b1 || scount_o !== 16'd2) begin
      miscompares++;
      $display("FAIL overrun_final: ov %b scount %0d want 1 2", overrun_o, scount_o);
    end
  endtask

  task automatic test_stop_wait_eos();
    int k; int s; bit ok;
    len_min = 20; len_max = 20;
    launch(50, 0, k);
    wait_sts(5, 400);
    s = (sts_q.size() >= 5) ? sts_q[4] : cyc;
    while (cyc < s + 5) tick(1);
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
    wait_done(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stopeos_done: no done within budget"); end
    tick(120);
    run_model(k, 50, 5);
    vectors++;
    if (sts_q.size() != 5 || done_q.size() != 1) begin
      miscompares++;
      $display("FAIL stopeos_counts: sts %0d dones %0d want 5 1", sts_q.size(), done_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= sts_q.size() || sts_q[i] != exp_q[i]) begin
        miscompares++;
        $display("FAIL stopeos_sts%0d: got %0d want %0d", i, (i < sts_q.size()) ? sts_q[i] : -1, exp_q[i]);
      end
    end
    vectors++;
    if (done_q.size() < 1 || done_q[0] != exp_done || scount_o !== 16'd5) begin
      miscompares++;
      $display("FAIL stopeos_final: done %0d scount %0d want %0d 5",
               (done_q.size() > 0) ? done_q[0] : -1, scount_o, exp_done);
    end
  endtask

  task automatic test_stop_pace();
    int k; int s; bit ok;
    len_min = 10; len_max = 10;
    launch(60, 0, k);
    wait_sts(2, 300);
    s = (sts_q.size() >= 2) ? sts_q[1] : cyc;
    while (cyc < s + 14) tick(1);
    period_i = PER_W'(3); nsamp_i = CNT_W'(1);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    while (cyc < s + 19) tick(1);
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
    wait_done(50, ok);
    vectors++;
    if (!ok || cyc != s + 20) begin
      miscompares++;
      $display("FAIL stoppace_done: got cycle %0d want %0d", cyc, s + 20);
    end
    tick(100);
    vectors++;
    if (sts_q.size() != 2 || sts_q[1] - sts_q[0] != 60) begin
      miscompares++;
      $display("FAIL stoppace_sts: count %0d want 2 spaced 60", sts_q.size());
    end
    vectors++;
    if (scount_o !== 16'd2 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stoppace_final: scount %0d busy %b want 2 0", scount_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int k; int s; bit ok;
    len_min = 30; len_max = 30;
    launch(10, 3, k);
    wait_sts(2, 200);
    s = (sts_q.size() >= 2) ? sts_q[1] : cyc;
    while (cyc < s + 15) tick(1);
    @(negedge clk_i); #2;
    vectors++;
    if (busy_o !== 1'b1 || overrun_o !== 1'b1 || scount_o !== 16'd1) begin
      miscompares++;
      $display("FAIL premid_state: busy %b ov %b scount %0d want 1 1 1", busy_o, overrun_o, scount_o);
    end
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({sts_o, busy_o, done_o, overrun_o, timeout_o} !== 5'b0 || scount_o !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: flags %b scount %0d want 00000 0",
               {sts_o, busy_o, done_o, overrun_o, timeout_o}, scount_o);
    end
    low_left = 0; eos_i = 1'b1;
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    len_min = 3; len_max = 6;
    launch(0, 2, k);
    wait_done(100, ok);
    tick(10);
    run_model(k, 2, 2);
    vectors++;
    if (sts_q.size() != 2 || sts_q[0] != k || sts_q[1] != exp_q[1]) begin
      miscompares++;
      $display("FAIL minper_sts: count %0d first %0d want 2 at %0d", sts_q.size(),
               (sts_q.size() > 0) ? sts_q[0] : -1, k);
    end
    vectors++;
    if (!ok || scount_o !== 16'd2 || overrun_o !== exp_ov) begin
      miscompares++;
      $display("FAIL minper_final: done %b scount %0d ov %b want 1 2 %b", ok, scount_o, overrun_o, exp_ov);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int k; int p_raw; int p; int n; bit ok;
      p_raw = $urandom_range(40, 0);
      p = (p_raw < 2) ? 2 : p_raw;
      n = $urandom_range(4, 1);
      len_min = 1; len_max = $urandom_range(45, 1);
      launch(p_raw, n, k);
      wait_done(n * 100 + 50, ok);
      tick(5);
      run_model(k, p, n);
      vectors++;
      if (!ok || sts_q.size() != n || done_q.size() != 1) begin
        miscompares++;
        $display("FAIL rand%0d_counts: done %b sts %0d dones %0d want 1 %0d 1", b, ok, sts_q.size(), done_q.size(), n);
      end
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (i >= sts_q.size() || sts_q[i] != exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d_sts%0d: got %0d want %0d (P=%0d)", b, i,
                   (i < sts_q.size()) ? sts_q[i] : -1, exp_q[i], p);
        end
      end
      vectors++;
      if (done_q.size() < 1 || done_q[0] != exp_done || overrun_o !== exp_ov || scount_o !== CNT_W'(n)) begin
        miscompares++;
        $display("FAIL rand%0d_final: done %0d ov %b scount %0d want %0d %b %0d", b,
                 (done_q.size() > 0) ? done_q[0] : -1, overrun_o, scount_o, exp_done, exp_ov, n);
      end
    end
  endtask

`ifdef ADC_SCHED_WDOG_EN
  task automatic test_wdog();
    int k; bit ok;
    eos_stuck = 1'b1;
    launch(200, 1, k);
    wait_done(200, ok);
    vectors++;
    if (!ok || cyc != k + WDOG) begin
      miscompares++;
      $display("FAIL wdog_done: got cycle %0d want %0d", cyc, k + WDOG);
    end
    tick(3);
    vectors++;
    if (timeout_o !== 1'b1 || scount_o !== '0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wdog_final: to %b scount %0d busy %b want 1 0 0", timeout_o, scount_o, busy_o);
    end
    eos_stuck = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_timely();
    test_overrun();
    test_stop_wait_eos();
    test_stop_pace();
    test_reset_mid();
    test_random();
`ifdef ADC_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
